int_exec_unit: RTL and testbench

Parametrised integer execute unit for the MIPS datapath. It is the next generation of the combined ALU/multiply/divide block and replaces a fixed 32-bit, 16×16 multiply design with a WIDTH-generic unit. It provides single-cycle ALU ops, a full-width signed/unsigned iterative multiplier and a signed/unsigned restoring divider behind one valid/ready handshake, and adds flush and divide-by-zero reporting. It sits in the EX stage between operand fetch and writeback; `out_lo` feeds the result bus and `out_hi` feeds the HI register.

---
 rtl/int_exec_unit_if.sv | 26 ++
 rtl/int_exec_unit.sv | 157 +++++++++++++++
 tb/tb_int_exec_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/int_exec_unit_if.sv
// Handshake and result bus of the integer execute unit.
// The issuing stage holds the master side and the unit holds the slave side.
interface int_exec_unit_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             div_zero;
  logic             busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out_lo, out_hi, div_zero, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out_lo, out_hi, div_zero, busy
  );
endinterface

// File: rtl/int_exec_unit.sv
// WIDTH-generic EX-stage unit: single-cycle ALU, iterative shift-add multiply
// and restoring divide on magnitudes, with the sign applied in DONE.
module int_exec_unit #(parameter int WIDTH = 32) (
  input logic            clk,
  input logic            reset,
  int_exec_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;   // hi: partial product / remainder, lo: multiplier / quotient
  logic [WIDTH-1:0]   opb;
  logic               is_mul, neg_q, neg_r, dz;

  logic               accept, op_mul, op_div, sgn, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b, alu_res;
  logic [WIDTH:0]     mul_sum, trial;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
  logic [WIDTH-1:0]   fin_lo, fin_hi;

  assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready) && !bus.flush;
  assign bus.busy     = (state == MUL) || (state == DIV);
  assign accept       = bus.in_valid && bus.in_ready;

  assign op_mul = (bus.op == 4'd8)  || (bus.op == 4'd9);
  assign op_div = (bus.op == 4'd10) || (bus.op == 4'd11);
  assign sgn    = (bus.op == 4'd9)  || (bus.op == 4'd11);
  assign sa     = sgn && bus.a[WIDTH-1];
  assign sb     = sgn && bus.b[WIDTH-1];
  assign mag_a  = sa ? -bus.a : bus.a;
  assign mag_b  = sb ? -bus.b : bus.b;

  always_comb begin
    alu_res = bus.a;
    case (bus.op)
      4'd0: alu_res = bus.a + bus.b;
      4'd1: alu_res = bus.a - bus.b;
      4'd2: alu_res = bus.a & bus.b;
      4'd3: alu_res = bus.a | bus.b;
      4'd4: alu_res = bus.a ^ bus.b;
      4'd5: alu_res = ~bus.a;
      4'd7: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_res = bus.a;
    endcase
  end

  // One multiply step: conditional add into the high half, then shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step; the difference always fits WIDTH bits when ge.
  assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign ge       = trial >= {1'b0, opb};
  assign diff     = trial[WIDTH-1:0] - opb;
  assign div_next = ge ? {diff, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};

  always_comb begin
    prod_neg = -acc;
    fin_lo   = acc[WIDTH-1:0];
    fin_hi   = acc[2*WIDTH-1:WIDTH];
    if (is_mul) begin
      if (neg_q) begin
        fin_lo = prod_neg[WIDTH-1:0];
        fin_hi = prod_neg[2*WIDTH-1:WIDTH];
      end
    end else begin
      if (neg_q) fin_lo = -acc[WIDTH-1:0];
      if (neg_r) fin_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      acc           <= '0;
      opb           <= '0;
      is_mul        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dz            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_lo    <= '0;
      bus.out_hi    <= '0;
      bus.div_zero  <= 1'b0;
    end else if (bus.flush) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_mul) begin
              acc           <= {{WIDTH{1'b0}}, mag_b};
              opb           <= mag_a;
              is_mul        <= 1'b1;
              neg_q         <= sa ^ sb;
              neg_r         <= 1'b0;
              dz            <= 1'b0;
              cnt           <= CW'(WIDTH);
              bus.out_valid <= 1'b0;
              state         <= MUL;
            end else if (op_div) begin
              is_mul        <= 1'b0;
              cnt           <= CW'(WIDTH);
              bus.out_valid <= 1'b0;
              if (bus.b == '0) begin
                // Divide by zero bypasses the iterations with the fixed result.
                acc   <= {bus.a, {WIDTH{1'b1}}};
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                dz    <= 1'b1;
                state <= DONE;
              end else begin
                acc   <= {{WIDTH{1'b0}}, mag_a};
                opb   <= mag_b;
                neg_q <= sa ^ sb;
                neg_r <= sa;
                dz    <= 1'b0;
                state <= DIV;
              end
            end else begin
              bus.out_lo    <= alu_res;
              bus.out_hi    <= '0;
              bus.div_zero  <= 1'b0;
              bus.out_valid <= 1'b1;
            end
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        DIV: begin
          acc <= div_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= DONE;
        end
        default: begin
          bus.out_lo    <= fin_lo;
          bus.out_hi    <= fin_hi;
          bus.div_zero  <= dz;
          bus.out_valid <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_int_exec_unit.sv
// Directed bench for int_exec_unit at WIDTH=32 and WIDTH=8.
module tb_int_exec_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int_exec_unit_if #(.WIDTH(32)) bus32();
  int_exec_unit_if #(.WIDTH(8))  bus8();

  int_exec_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  int_exec_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct {
    bit          w8;
    logic [3:0]  op;
    logic [63:0] a, b, lo, hi;
    logic        dz;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input bit w8, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] lo, output logic [63:0] hi, output logic dz, output int lat);
    logic rdy, vld;
    @(negedge clk);
    if (w8) begin
      bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.in_valid = 1'b1;
    end else begin
      bus32.op = op; bus32.a = a[31:0]; bus32.b = b[31:0]; bus32.in_valid = 1'b1;
    end
    rdy = 1'b0;
    for (int n = 0; n < 100 && !rdy; n++) begin
      #1 rdy = w8 ? bus8.in_ready : bus32.in_ready;
      if (!rdy) @(negedge clk);
    end
    chk("accept", {63'd0, rdy}, 64'd1);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus32.in_valid = 1'b0;
    lat = 0;
    vld = 1'b0;
    while (!vld && lat < 100) begin
      @(negedge clk);
      lat++;
      vld = w8 ? bus8.out_valid : bus32.out_valid;
    end
    lo = w8 ? {56'd0, bus8.out_lo} : {32'd0, bus32.out_lo};
    hi = w8 ? {56'd0, bus8.out_hi} : {32'd0, bus32.out_hi};
    dz = w8 ? bus8.div_zero : bus32.div_zero;
  endtask

  initial begin
    vec_t        vt[$];
    logic [63:0] lo, hi;
    logic        dz, seen;
    int          lat;

    bus32.flush = 0; bus32.in_valid = 0; bus32.op = 0; bus32.a = 0; bus32.b = 0; bus32.out_ready = 1;
    bus8.flush  = 0; bus8.in_valid  = 0; bus8.op  = 0; bus8.a  = 0; bus8.b  = 0; bus8.out_ready  = 1;

    vt.push_back('{0, 4'd0,  64'hFFFFFFFF, 64'h1,        64'h0,        64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd1,  64'h5,        64'h7,        64'hFFFFFFFE, 64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd2,  64'hF0F0F0F0, 64'h0FF00FF0, 64'h00F000F0, 64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd3,  64'hF0F0F0F0, 64'h0F0F0000, 64'hFFFFF0F0, 64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd4,  64'hAAAA5555, 64'hFFFF0000, 64'h55555555, 64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd5,  64'h12345678, 64'h0,        64'hEDCBA987, 64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd6,  64'hDEADBEEF, 64'h1,        64'hDEADBEEF, 64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd7,  64'h80000000, 64'h0,        64'h1,        64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd7,  64'h5,        64'h3,        64'h0,        64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd13, 64'h0BADF00D, 64'h5,        64'h0BADF00D, 64'h0,        1'b0, 1});
    vt.push_back('{0, 4'd9,  64'hFFFFFFFD, 64'h7,        64'hFFFFFFEB, 64'hFFFFFFFF, 1'b0, 34});
    vt.push_back('{0, 4'd8,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000001, 64'hFFFFFFFE, 1'b0, 34});
    vt.push_back('{0, 4'd9,  64'hFFFFFFFE, 64'hFFFFFFFB, 64'hA,        64'h0,        1'b0, 34});
    vt.push_back('{0, 4'd8,  64'h00010000, 64'h00010000, 64'h0,        64'h1,        1'b0, 34});
    vt.push_back('{0, 4'd11, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 64'hFFFFFFFF, 1'b0, 34});
    vt.push_back('{0, 4'd10, 64'd100,      64'd7,        64'd14,       64'd2,        1'b0, 34});
    vt.push_back('{0, 4'd11, 64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, 64'h1,        1'b0, 34});
    vt.push_back('{0, 4'd10, 64'd100,      64'd0,        64'hFFFFFFFF, 64'd100,      1'b1, 2});
    vt.push_back('{0, 4'd11, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 64'h0,        1'b0, 34});
    vt.push_back('{0, 4'd11, 64'hFFFFFFFB, 64'h0,        64'hFFFFFFFF, 64'hFFFFFFFB, 1'b1, 2});
    vt.push_back('{1, 4'd8,  64'hFF,       64'hFF,       64'h01,       64'hFE,       1'b0, 10});
    vt.push_back('{1, 4'd11, 64'h80,       64'hFF,       64'h80,       64'h00,       1'b0, 10});
    vt.push_back('{1, 4'd9,  64'h80,       64'h80,       64'h00,       64'h40,       1'b0, 10});
    vt.push_back('{1, 4'd10, 64'd200,      64'd0,        64'hFF,       64'hC8,       1'b1, 2});
    vt.push_back('{1, 4'd11, 64'hF9,       64'h02,       64'hFD,       64'hFF,       1'b0, 10});

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
    chk("rst_out_lo",    {32'd0, bus32.out_lo}, 64'd0);
    chk("rst_out_hi",    {32'd0, bus32.out_hi}, 64'd0);
    chk("rst_div_zero",  {63'd0, bus32.div_zero}, 64'd0);
    chk("rst_busy",      {63'd0, bus32.busy}, 64'd0);
    reset = 1'b1;
    #1 chk("rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);

    foreach (vt[i]) begin
      run_op(vt[i].w8, vt[i].op, vt[i].a, vt[i].b, lo, hi, dz, lat);
      chk($sformatf("v%0d_lo", i),  lo, vt[i].lo);
      chk($sformatf("v%0d_hi", i),  hi, vt[i].hi);
      chk($sformatf("v%0d_dz", i),  {63'd0, dz}, {63'd0, vt[i].dz});
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
    end

    // Back-to-back ALU ops with out_ready held high
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i), {63'd0, bus32.out_valid}, 64'd1);
        chk($sformatf("b2b%0d_lo", i), {32'd0, bus32.out_lo}, 64'(i * 10));
      end
      bus32.op = 4'd0; bus32.a = 32'(i * 10 + 9); bus32.b = 32'd1; bus32.in_valid = 1'b1;
      #1 chk($sformatf("b2b%0d_rdy", i), {63'd0, bus32.in_ready}, 64'd1);
    end
    @(negedge clk);
    bus32.in_valid = 1'b0;
    chk("b2b4_lo", {32'd0, bus32.out_lo}, 64'd40);

    // Result hold under back-pressure, then replace with a same-cycle accept
    @(negedge clk);
    bus32.out_ready = 1'b0;
    bus32.op = 4'd0; bus32.a = 32'd1; bus32.b = 32'd2; bus32.in_valid = 1'b1;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    seen = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(bus32.out_valid && bus32.out_lo == 32'd3 && bus32.out_hi == 32'd0 &&
            !bus32.div_zero && !bus32.in_ready)) seen = 1'b0;
    end
    chk("hold_stable", {63'd0, seen}, 64'd1);
    @(negedge clk);
    bus32.out_ready = 1'b1;
    bus32.op = 4'd0; bus32.a = 32'd10; bus32.b = 32'd20; bus32.in_valid = 1'b1;
    #1 chk("hold_release_rdy", {63'd0, bus32.in_ready}, 64'd1);
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    @(negedge clk);
    chk("hold_new_valid", {63'd0, bus32.out_valid}, 64'd1);
    chk("hold_new_lo", {32'd0, bus32.out_lo}, 64'd30);
    @(negedge clk);
    chk("hold_drop_valid", {63'd0, bus32.out_valid}, 64'd0);

    // Flush at iteration 10 of a DIVU
    @(negedge clk);
    bus32.op = 4'd10; bus32.a = 32'd1000; bus32.b = 32'd3; bus32.in_valid = 1'b1;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("flush_pre_busy", {63'd0, bus32.busy}, 64'd1);
    bus32.flush = 1'b1;
    @(posedge clk);
    #1 bus32.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'd0, bus32.busy}, 64'd0);
    chk("flush_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.out_valid) seen = 1'b1;
    end
    chk("flush_no_result", {63'd0, seen}, 64'd0);

    // Flush wins over a same-cycle accept
    @(negedge clk);
    bus32.flush = 1'b1;
    bus32.op = 4'd0; bus32.a = 32'd4; bus32.b = 32'd4; bus32.in_valid = 1'b1;
    #1 chk("flush_blocks_rdy", {63'd0, bus32.in_ready}, 64'd0);
    @(posedge clk);
    #1 begin bus32.flush = 1'b0; bus32.in_valid = 1'b0; end
    @(negedge clk);
    chk("flush_no_accept", {63'd0, bus32.out_valid}, 64'd0);

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    bus32.op = 4'd8; bus32.a = 32'd3; bus32.b = 32'd5; bus32.in_valid = 1'b1;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy", {63'd0, bus32.busy}, 64'd1);
    chk("pre_reset_lo", {32'd0, bus32.out_lo}, 64'd30);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", {63'd0, bus32.busy}, 64'd0);
    chk("arst_valid", {63'd0, bus32.out_valid}, 64'd0);
    chk("arst_lo", {32'd0, bus32.out_lo}, 64'd0);
    chk("arst_hi", {32'd0, bus32.out_hi}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("arst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.out_valid) seen = 1'b1;
    end
    chk("arst_discard", {63'd0, seen}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
